csa_accumulator: RTL and testbench

Streaming multi-operand accumulator that sums an arbitrary-length stream of N-bit unsigned operands, L lanes per beat. The running total is kept in redundant carry-save form: a sum vector and a carry vector. A single carry-propagate add is performed once per frame, after the last beat. The block is the sequential, parametrised successor to the team's combinational M-operand carry-save adder and sits between an operand source and any result consumer, using valid/ready handshakes on both sides.

---
 rtl/csa_pkg.sv | 14 +
 rtl/csa_accumulator.sv | 171 +++++++++++++++++
 tb/tb_csa_accumulator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save stream accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } csa_state_t;

  function automatic int csa_acc_width(input int n, input int max_ops);
    return n + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_accumulator.sv
// Streaming L-lane accumulator: running total held as carry-save S/C vectors,
// resolved by one carry-propagate add per frame.
module csa_compress_row
  #(parameter int W = 8)
  (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
  );

  logic [W-1:0] maj;

  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  // Carry weight is one bit higher; the MSB carry drops out (modulo 2^W).
  assign cy  = {maj[W-2:0], 1'b0};

endmodule

module csa_accumulator
  import csa_pkg::*;
  #(
    parameter  int N       = 4,
    parameter  int L       = 2,
    parameter  int MAX_OPS = 16,
    localparam int W       = csa_acc_width(N, MAX_OPS),
    localparam int CW      = $clog2(MAX_OPS) + 1
  )
  (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [L*N-1:0] in_data,
    input  logic [L-1:0]   in_keep,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sum,
    output logic [CW-1:0]  out_count,
    output logic           out_ovf
  );

  localparam int XW = CW + $clog2(L + 1);

  csa_state_t     state_q, state_d;
  logic [W-1:0]   s_q, s_d, c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   out_sum_q, out_sum_d;
  logic [CW-1:0]  out_count_q, out_count_d;
  logic           out_ovf_q, out_ovf_d;

  logic [W-1:0]   tree_s, tree_c;
  logic [XW-1:0]  pop, cnt_ext;
  logic           accept, release_out;

  // One 3:2 row per lane, each folding its lane into the running S/C pair.
  for (genvar r = 0; r < L; r++) begin : g_row
    logic [W-1:0] s_in, c_in, lane, s_o, c_o;

    if (r == 0) begin : g_first
      assign s_in = s_q;
      assign c_in = c_q;
    end else begin : g_next
      assign s_in = g_row[r-1].s_o;
      assign c_in = g_row[r-1].c_o;
    end

    assign lane = in_keep[r] ? W'(in_data[r*N +: N]) : '0;

    csa_compress_row #(.W(W)) u_row (
      .a  (s_in),
      .b  (c_in),
      .c  (lane),
      .s  (s_o),
      .cy (c_o)
    );
  end

  assign tree_s = g_row[L-1].s_o;
  assign tree_c = g_row[L-1].c_o;

  always_comb begin
    pop = '0;
    for (int k = 0; k < L; k++) begin
      pop = pop + XW'(in_keep[k]);
    end
    cnt_ext = XW'(cnt_q) + pop;
  end

  assign in_ready    = (state_q == ACC);
  assign out_valid   = (state_q == HOLD);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      ACC: begin
        if (accept) begin
          s_d = tree_s;
          c_d = tree_c;
          // Count saturates at MAX_OPS; going past it marks the frame as overflowed.
          if (cnt_ext > XW'(MAX_OPS)) begin
            cnt_d = CW'(MAX_OPS);
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_ext[CW-1:0];
          end
          if (in_last) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        out_sum_d   = s_q + c_q;
        out_count_d = cnt_q;
        out_ovf_d   = ovf_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (release_out) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and randomised frame checks for csa_accumulator at N=4, L=2, MAX_OPS=16.
module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_keep;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [4:0] out_count;
  logic       out_ovf;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.N(4), .L(2), .MAX_OPS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted; leaves in_valid high.
  task automatic send_beat(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [1:0] keep, input logic last);
    int   g;
    logic rdy;
    in_valid = 1'b1;
    in_data  = {d1, d0};
    in_keep  = keep;
    in_last  = last;
    g = 0;
    do begin
      rdy = in_ready;
      tick();
      g++;
    end while (!rdy && g < 50);
    if (!rdy) chk("accept_timeout", 0, 1);
  endtask

  // Wait for a result, stall the consumer for 'stall' cycles, check, then release it.
  task automatic collect(input string tag, input logic [7:0] exp_sum,
                         input logic [4:0] exp_cnt, input logic exp_ovf, input int stall);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) tick();
    end
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_count"}, out_count, exp_cnt);
    chk({tag, "_ovf"}, out_ovf, exp_ovf);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int t0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    tick();

    // Basic sum: 3+5+15+15 = 38, two beats back to back.
    t0 = int'($time);
    send_beat(4'd3, 4'd5, 2'b11, 1'b0);
    send_beat(4'd15, 4'd15, 2'b11, 1'b1);
    in_valid = 1'b0;
    chk("basic_two_beat_cycles", int'($time) - t0, 20);
    chk("basic_resolve_no_valid", out_valid, 0);
    chk("basic_resolve_no_ready", in_ready, 0);
    tick();
    chk("basic_latency_valid", out_valid, 1);
    collect("basic", 8'd38, 5'd4, 1'b0, 0);
    chk("basic_back_to_acc", in_ready, 1);

    // Lane masking.
    send_beat(4'd7, 4'd9, 2'b01, 1'b1);
    in_valid = 1'b0;
    collect("mask01", 8'd7, 5'd1, 1'b0, 0);
    send_beat(4'd7, 4'd9, 2'b00, 1'b1);
    in_valid = 1'b0;
    collect("mask00", 8'd0, 5'd0, 1'b0, 0);
    send_beat(4'd6, 4'd11, 2'b10, 1'b1);
    in_valid = 1'b0;
    collect("mask10", 8'd11, 5'd1, 1'b0, 0);

    // Overflow: 18 operands of 15 = 270 -> 14 mod 256.
    for (int b = 0; b < 9; b++) send_beat(4'd15, 4'd15, 2'b11, logic'(b == 8));
    in_valid = 1'b0;
    collect("ovf", 8'd14, 5'd16, 1'b1, 0);

    // Exactly MAX_OPS operands is not an overflow: 16*15 = 240.
    for (int b = 0; b < 8; b++) send_beat(4'd15, 4'd15, 2'b11, logic'(b == 7));
    in_valid = 1'b0;
    collect("full", 8'd240, 5'd16, 1'b0, 0);

    // Backpressure: next beat pending while HOLD is stalled.
    out_ready = 1'b0;
    send_beat(4'd4, 4'd6, 2'b11, 1'b1);
    in_data  = {4'd1, 4'd1};
    in_keep  = 2'b11;
    in_last  = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sum_stable", out_sum, 10);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    send_beat(4'd1, 4'd1, 2'b11, 1'b1);
    in_valid = 1'b0;
    collect("bp_next", 8'd2, 5'd2, 1'b0, 0);

    // Reset mid-frame discards the partial sum.
    send_beat(4'd15, 4'd15, 2'b11, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    send_beat(4'd2, 4'd3, 2'b11, 1'b1);
    in_valid = 1'b0;
    collect("midrst", 8'd5, 5'd2, 1'b0, 0);

    // Reset during HOLD.
    send_beat(4'd9, 4'd9, 2'b11, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("holdrst_out_valid", out_valid, 0);
    chk("holdrst_out_sum", out_sum, 0);
    chk("holdrst_in_ready", in_ready, 1);

    // Random frames against a scoreboard.
    for (int f = 0; f < 40; f++) begin
      int          nb;
      int          exp_sum;
      int          exp_cnt;
      logic [3:0]  a, b;
      logic [1:0]  k;
      nb = int'($urandom_range(1, 8));
      exp_sum = 0;
      exp_cnt = 0;
      for (int j = 0; j < nb; j++) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        k = 2'($urandom_range(0, 3));
        if (k[0]) begin exp_sum += int'(a); exp_cnt++; end
        if (k[1]) begin exp_sum += int'(b); exp_cnt++; end
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
        send_beat(a, b, k, logic'(j == nb - 1));
      end
      in_valid = 1'b0;
      collect("rand", 8'(exp_sum % 256), 5'(exp_cnt), 1'b0, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
